// File: rtl/cmd_sequencer.sv
// Host command FIFO feeding a single-issue sequencer that drives the register
// file and execution unit, retiring instructions strictly in program order.
module cmd_sequencer #(
    parameter int         DEPTH    = 4,
    parameter logic [4:0] CMD_ADDR = 5'd0,
    parameter logic [4:0] CLR_ADDR = 5'd1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   write,
    input  logic [4:0]             write_addr,
    input  logic [31:0]            write_data,
    output logic [$clog2(DEPTH):0] cmd_count,
    output logic                   cmd_full,
    output logic                   busy,
    output logic                   err_overflow,
    output logic                   err_illegal,
    output logic [4:0]             rf_raddr1,
    output logic [4:0]             rf_raddr2,
    input  logic [31:0]            rf_rdata1,
    input  logic [31:0]            rf_rdata2,
    output logic                   rf_we,
    output logic [4:0]             rf_waddr,
    output logic [31:0]            rf_wdata,
    output logic                   exu_start,
    output logic [3:0]             exu_op,
    output logic [31:0]            exu_a,
    output logic [31:0]            exu_b,
    input  logic                   exu_done,
    input  logic [31:0]            exu_result,
    output logic                   retired
);
    localparam int            AW         = $clog2(DEPTH);
    localparam int            CW         = AW + 1;
    localparam int            IW         = 25;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [3:0]    OP_NOP     = 4'd0;
    localparam logic [3:0]    OP_LOAD    = 4'd8;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_DISPATCH = 3'd1,
        S_READ     = 3'd2,
        S_START    = 3'd3,
        S_WAIT     = 3'd4,
        S_WB       = 3'd5
    } state_t;

    // ------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------
    logic [IW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic          w_cmd_wr;
    logic          w_push;
    logic          w_pop;
    logic          w_overflow;
    logic          w_clear;
    logic          w_full;
    logic          w_empty;
    logic [IW-1:0] w_head;
    logic          w_head_is_exu;
    logic          w_unused_bits;

    // Bits [31:25] of an instruction word carry no meaning.
    assign w_unused_bits = ^write_data[31:25];

    assign w_full        = (r_count == FULL_COUNT);
    assign w_empty       = (r_count == '0);
    assign w_cmd_wr      = write && (write_addr == CMD_ADDR);
    assign w_push        = w_cmd_wr && !w_full;
    assign w_overflow    = w_cmd_wr && w_full;
    assign w_clear       = write && (write_addr == CLR_ADDR) && write_data[0];
    assign w_head        = r_mem[r_rd_ptr];
    assign w_head_is_exu = (w_head[24:21] != OP_NOP) && !w_head[24];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= write_data[IW-1:0];
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------
    state_t        r_state;
    state_t        w_state_next;
    logic [IW-1:0] r_instr;

    logic [3:0]    w_op;
    logic [4:0]    w_rd;
    logic [15:0]   w_imm;
    logic          w_is_illegal;

    assign w_op         = r_instr[24:21];
    assign w_rd         = r_instr[20:16];
    assign w_imm        = r_instr[15:0];
    assign w_is_illegal = w_op[3] && (w_op != OP_LOAD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_instr <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_pop) begin
                r_instr <= w_head;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_state_next = S_DISPATCH;
                end
            end
            S_DISPATCH: begin
                if (w_op == OP_NOP || w_is_illegal) begin
                    w_state_next = S_IDLE;
                end else if (w_op == OP_LOAD) begin
                    w_state_next = S_WB;
                end else begin
                    w_state_next = S_READ;
                end
            end
            S_READ:  w_state_next = S_START;
            S_START: w_state_next = S_WAIT;
            S_WAIT: begin
                if (exu_done) begin
                    w_state_next = S_WB;
                end
            end
            S_WB: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_state_next = S_DISPATCH;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Registered outputs: next values computed here, one cycle ahead of
    // the state in which they must be visible.
    // ------------------------------------------------------------------
    logic [4:0]  r_rf_raddr1, w_rf_raddr1_next;
    logic [4:0]  r_rf_raddr2, w_rf_raddr2_next;
    logic        r_rf_we,     w_rf_we_next;
    logic [4:0]  r_rf_waddr,  w_rf_waddr_next;
    logic [31:0] r_rf_wdata,  w_rf_wdata_next;
    logic        r_exu_start, w_exu_start_next;
    logic [3:0]  r_exu_op,    w_exu_op_next;
    logic [31:0] r_exu_a,     w_exu_a_next;
    logic [31:0] r_exu_b,     w_exu_b_next;
    logic        r_retired,   w_retired_next;
    logic        w_illegal_set;

    always_comb begin
        w_rf_raddr1_next = r_rf_raddr1;
        w_rf_raddr2_next = r_rf_raddr2;
        w_rf_we_next     = 1'b0;
        w_rf_waddr_next  = r_rf_waddr;
        w_rf_wdata_next  = r_rf_wdata;
        w_exu_start_next = 1'b0;
        w_exu_op_next    = r_exu_op;
        w_exu_a_next     = r_exu_a;
        w_exu_b_next     = r_exu_b;
        w_retired_next   = 1'b0;
        w_illegal_set    = 1'b0;

        // Read addresses go out with the pop so the synchronous RF data
        // lands exactly in the READ cycle.
        if (w_pop && w_head_is_exu) begin
            w_rf_raddr1_next = w_head[15:11];
            w_rf_raddr2_next = w_head[10:6];
        end

        case (r_state)
            S_DISPATCH: begin
                if (w_op == OP_NOP) begin
                    w_retired_next = 1'b1;
                end else if (w_is_illegal) begin
                    w_retired_next = 1'b1;
                    w_illegal_set  = 1'b1;
                end else if (w_op == OP_LOAD) begin
                    w_rf_we_next    = 1'b1;
                    w_retired_next  = 1'b1;
                    w_rf_waddr_next = w_rd;
                    w_rf_wdata_next = {16'h0000, w_imm};
                end else begin
                    w_exu_op_next = w_op;
                end
            end
            S_READ: begin
                w_exu_a_next     = rf_rdata1;
                w_exu_b_next     = rf_rdata2;
                w_exu_start_next = 1'b1;
            end
            S_WAIT: begin
                if (exu_done) begin
                    w_rf_we_next    = 1'b1;
                    w_retired_next  = 1'b1;
                    w_rf_waddr_next = w_rd;
                    w_rf_wdata_next = exu_result;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rf_raddr1 <= '0;
            r_rf_raddr2 <= '0;
            r_rf_we     <= 1'b0;
            r_rf_waddr  <= '0;
            r_rf_wdata  <= '0;
            r_exu_start <= 1'b0;
            r_exu_op    <= '0;
            r_exu_a     <= '0;
            r_exu_b     <= '0;
            r_retired   <= 1'b0;
        end else begin
            r_rf_raddr1 <= w_rf_raddr1_next;
            r_rf_raddr2 <= w_rf_raddr2_next;
            r_rf_we     <= w_rf_we_next;
            r_rf_waddr  <= w_rf_waddr_next;
            r_rf_wdata  <= w_rf_wdata_next;
            r_exu_start <= w_exu_start_next;
            r_exu_op    <= w_exu_op_next;
            r_exu_a     <= w_exu_a_next;
            r_exu_b     <= w_exu_b_next;
            r_retired   <= w_retired_next;
        end
    end

    // Sticky errors: a set in the same cycle as a clear takes priority.
    logic r_err_overflow;
    logic r_err_illegal;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_overflow <= 1'b0;
            r_err_illegal  <= 1'b0;
        end else begin
            if (w_overflow) begin
                r_err_overflow <= 1'b1;
            end else if (w_clear) begin
                r_err_overflow <= 1'b0;
            end
            if (w_illegal_set) begin
                r_err_illegal <= 1'b1;
            end else if (w_clear) begin
                r_err_illegal <= 1'b0;
            end
        end
    end

    assign cmd_count    = r_count;
    assign cmd_full     = w_full;
    assign busy         = (r_state != S_IDLE) || !w_empty;
    assign err_overflow = r_err_overflow;
    assign err_illegal  = r_err_illegal;
    assign rf_raddr1    = r_rf_raddr1;
    assign rf_raddr2    = r_rf_raddr2;
    assign rf_we        = r_rf_we;
    assign rf_waddr     = r_rf_waddr;
    assign rf_wdata     = r_rf_wdata;
    assign exu_start    = r_exu_start;
    assign exu_op       = r_exu_op;
    assign exu_a        = r_exu_a;
    assign exu_b        = r_exu_b;
    assign retired      = r_retired;

endmodule

// File: tb/tb_cmd_sequencer.sv
// Scoreboard bench for cmd_sequencer: directed host writes push expected EXU
// starts and register writes; a negedge monitor pops and compares them.
module tb_cmd_sequencer;
    localparam int         DEPTH    = 4;
    localparam logic [4:0] CMD_ADDR = 5'd0;
    localparam logic [4:0] CLR_ADDR = 5'd1;

    logic        clk = 1'b0;
    logic        rst;
    logic        write;
    logic [4:0]  write_addr;
    logic [31:0] write_data;
    logic [2:0]  cmd_count;
    logic        cmd_full;
    logic        busy;
    logic        err_overflow;
    logic        err_illegal;
    logic [4:0]  rf_raddr1;
    logic [4:0]  rf_raddr2;
    logic [31:0] rf_rdata1 = '0;
    logic [31:0] rf_rdata2 = '0;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        exu_start;
    logic [3:0]  exu_op;
    logic [31:0] exu_a;
    logic [31:0] exu_b;
    logic        exu_done;
    logic [31:0] exu_result;
    logic        retired;

    cmd_sequencer #(.DEPTH(DEPTH), .CMD_ADDR(CMD_ADDR), .CLR_ADDR(CLR_ADDR)) dut (
        .clk(clk), .rst(rst), .write(write), .write_addr(write_addr),
        .write_data(write_data), .cmd_count(cmd_count), .cmd_full(cmd_full),
        .busy(busy), .err_overflow(err_overflow), .err_illegal(err_illegal),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1),
        .rf_rdata2(rf_rdata2), .rf_we(rf_we), .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata), .exu_start(exu_start), .exu_op(exu_op),
        .exu_a(exu_a), .exu_b(exu_b), .exu_done(exu_done),
        .exu_result(exu_result), .retired(retired)
    );

    always #5 clk = ~clk;

    typedef struct { int cyc; logic [4:0] addr; logic [31:0] data; } wb_t;
    typedef struct { int cyc; logic [3:0] op; logic [31:0] a; logic [31:0] b; } ex_t;

    wb_t exp_wb[$];
    ex_t exp_ex[$];
    int  wb_cyc[$];
    int  wb_cnt[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    int  n_retired = 0;
    int  exu_lat = 5;

    logic [31:0] rf_mem [32];

    always @(posedge clk) cyc <= cyc + 1;

    // Register file with one-cycle synchronous read.
    always @(posedge clk) begin
        rf_rdata1 <= rf_mem[rf_raddr1];
        rf_rdata2 <= rf_mem[rf_raddr2];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // EXU model: result = a + b, completing exu_lat cycles after start.
    initial begin : exu_model
        int          cnt;
        logic        pend;
        logic [31:0] ca, cb;
        pend = 1'b0; cnt = 0; ca = '0; cb = '0;
        exu_done = 1'b0; exu_result = '0;
        forever begin
            @(posedge clk); #1;
            exu_done = 1'b0;
            if (rst) begin
                pend = 1'b0;
            end else begin
                if (pend) begin
                    if (cnt == 1) begin
                        exu_done   = 1'b1;
                        exu_result = ca + cb;
                        pend       = 1'b0;
                    end else begin
                        cnt--;
                    end
                end
                if (exu_start) begin
                    pend = 1'b1; cnt = exu_lat; ca = exu_a; cb = exu_b;
                end
            end
        end
    end

    // Monitor: every EXU start and register write must match the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (exu_start) begin
                if (exp_ex.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL ex_unexpected actual=start op=%0d required=none (cycle %0d)", exu_op, cyc);
                end else begin
                    ex_t e;
                    e = exp_ex.pop_front();
                    chk("ex_op", {28'h0, exu_op}, {28'h0, e.op});
                    chk("ex_a", exu_a, e.a);
                    chk("ex_b", exu_b, e.b);
                    if (e.cyc >= 0) chk("ex_cycle", cyc, e.cyc);
                    $display("EXU start op=%0d a=%h b=%h cycle=%0d", exu_op, exu_a, exu_b, cyc);
                end
            end
            if (rf_we) begin
                wb_cyc.push_back(cyc);
                wb_cnt.push_back(int'(cmd_count));
                chk("wb_retired", {31'h0, retired}, 32'h1);
                if (exp_wb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL wb_unexpected actual=r%0d<=%h required=none (cycle %0d)", rf_waddr, rf_wdata, cyc);
                end else begin
                    wb_t w;
                    w = exp_wb.pop_front();
                    chk("wb_addr", {27'h0, rf_waddr}, {27'h0, w.addr});
                    chk("wb_data", rf_wdata, w.data);
                    if (w.cyc >= 0) chk("wb_cycle", cyc, w.cyc);
                    $display("WB r%0d <= %h cycle=%0d", rf_waddr, rf_wdata, cyc);
                end
            end
            if (retired) n_retired++;
        end
    end

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic host_wr(input logic [4:0] a, input logic [31:0] d);
        write = 1'b1; write_addr = a; write_data = d;
        @(posedge clk); #1;
        write = 1'b0;
        $display("HOST write addr=%0d data=%h", a, d);
    endtask

    task automatic wait_drain(input int max_cyc, input string name);
        int n;
        n = 0;
        while ((busy || exp_wb.size() != 0) && n < max_cyc) begin
            @(posedge clk); #1; n++;
        end
        checks++;
        if (n >= max_cyc) begin
            errors++;
            $display("FAIL %s_timeout actual=%0d cycles required=<%0d", name, n, max_cyc);
        end
    endtask

    function automatic logic [31:0] ld(input logic [4:0] rd, input logic [15:0] imm);
        return {7'h0, 4'h8, rd, imm};
    endfunction

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int c;
        int base;
        for (int i = 0; i < 32; i++) rf_mem[i] = '0;
        rf_mem[4] = 32'h11;
        rf_mem[5] = 32'h22;
        rst = 1'b1; write = 1'b0; write_addr = '0; write_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_count", {29'h0, cmd_count}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_outs", {26'h0, rf_we, retired, exu_start, err_overflow, err_illegal, cmd_full}, 32'h0);
        chk("rst_raddr", {22'h0, rf_raddr1, rf_raddr2}, 32'h0);
        @(posedge clk); #1 rst = 1'b0;
        step(2);

        // LOAD r13 <= 0xabcd, written in cycle c, writes back in c+3
        c = cyc;
        exp_wb.push_back('{c + 3, 5'd13, 32'h0000abcd});
        host_wr(CMD_ADDR, 32'h010dabcd);
        wait_drain(20, "load");

        // op3 r3 <= r4 op r5: start in c+4, done 5 cycles later, WB in c+10
        c = cyc;
        exp_ex.push_back('{c + 4, 4'd3, 32'h11, 32'h22});
        exp_wb.push_back('{c + 10, 5'd3, 32'h33});
        host_wr(CMD_ADDR, 32'h00632140);
        wait_drain(40, "exu");

        // Burst of DEPTH+1 LOADs behind a stalled op1
        exu_lat = 20;
        exp_ex.push_back('{-1, 4'd1, 32'h11, 32'h22});
        exp_wb.push_back('{-1, 5'd2, 32'h33});
        host_wr(CMD_ADDR, 32'h00222140);
        step(3);
        base = wb_cyc.size();
        for (int i = 0; i < DEPTH + 1; i++) begin
            if (i < DEPTH) exp_wb.push_back('{-1, 5'(20 + i), 32'h1000 + 32'(i)});
            host_wr(CMD_ADDR, ld(5'(20 + i), 16'(16'h1000 + i)));
        end
        @(negedge clk);
        chk("burst_count", {29'h0, cmd_count}, 32'd4);
        chk("burst_full", {31'h0, cmd_full}, 32'h1);
        chk("burst_ovf", {31'h0, err_overflow}, 32'h1);
        @(posedge clk); #1;
        host_wr(CLR_ADDR, 32'h1);
        @(negedge clk);
        chk("clr_ovf", {31'h0, err_overflow}, 32'h0);
        @(posedge clk); #1;
        wait_drain(100, "burst");
        chk("burst_wb_n", wb_cyc.size(), base + 5);
        if (wb_cyc.size() == base + 5) begin
            for (int k = 0; k < 5; k++) begin
                chk("burst_pop_count", wb_cnt[base + k], 32'(4 - k));
                if (k > 0) chk("burst_spacing", wb_cyc[base + k] - wb_cyc[base + k - 1], 32'd2);
            end
        end

        // NOP, illegal op12, then LOAD r9 retiring in c+7
        exu_lat = 5;
        c = cyc;
        exp_wb.push_back('{c + 7, 5'd9, 32'h00005a5a});
        host_wr(CMD_ADDR, 32'h00000000);
        host_wr(CMD_ADDR, 32'h01870000);
        host_wr(CMD_ADDR, ld(5'd9, 16'h5a5a));
        wait_drain(30, "illegal");
        step(2);
        chk("illegal_flag", {31'h0, err_illegal}, 32'h1);
        chk("illegal_ovf", {31'h0, err_overflow}, 32'h0);
        host_wr(CLR_ADDR, 32'h1);
        @(negedge clk);
        chk("clr_illegal", {31'h0, err_illegal}, 32'h0);
        @(posedge clk); #1;

        // Reset while waiting on the EXU with a LOAD still queued
        exu_lat = 30;
        c = cyc;
        exp_ex.push_back('{c + 4, 4'd2, 32'h11, 32'h22});
        host_wr(CMD_ADDR, 32'h00462140);
        host_wr(CMD_ADDR, ld(5'd10, 16'hbeef));
        step(8);
        @(negedge clk);
        chk("pre_rst_count", {29'h0, cmd_count}, 32'd1);
        chk("pre_rst_busy", {31'h0, busy}, 32'h1);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_count", {29'h0, cmd_count}, 32'h0);
        chk("mid_rst_busy", {31'h0, busy}, 32'h0);
        chk("mid_rst_exu_a", exu_a, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        step(45);
        chk("post_rst_busy", {31'h0, busy}, 32'h0);
        chk("post_rst_ex_left", exp_ex.size(), 32'h0);
        chk("retired_total", n_retired, 32'd10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cmd_sequencer.md
Name: cmd_sequencer

Overview:
- Sits between the host register-write port and the coprocessor datapath.
- Host instruction words written to CMD_ADDR are queued in a small FIFO. The block then decodes, sequences and retires them one at a time, in order.
- LOAD writes an immediate straight to the register file. Compute ops read two source registers, start the execution unit (EXU), wait for it, and write back.
- Sticky error flags are cleared by a host write to CLR_ADDR.

Parameters:
DEPTH, 4, command FIFO entries (power of 2, >=2)
CMD_ADDR, 5'd0, host address that enqueues an instruction
CLR_ADDR, 5'd1, host address that clears error flags (write_data[0]=1)

Ports:
clk  in  1  clock; all state on rising edge
rst  in  1  asynchronous active-high reset
write  in  1  host write strobe, one word per cycle
write_addr  in  5  host write address
write_data  in  32  host write data
cmd_count  out  $clog2(DEPTH)+1  FIFO occupancy
cmd_full  out  1  cmd_count==DEPTH
busy  out  1  FSM not IDLE or FIFO non-empty
err_overflow  out  1  sticky: enqueue attempted while full
err_illegal  out  1  sticky: opcode 9..15 dispatched
rf_raddr1, rf_raddr2  out  5  register-file read addresses (sync read, 1-cycle latency)
rf_rdata1, rf_rdata2  in  32  register-file read data
rf_we  out  1  register-file write pulse
rf_waddr  out  5  write address
rf_wdata  out  32  write data
exu_start  out  1  single-cycle start pulse
exu_op  out  4  operation to EXU
exu_a, exu_b  out  32  operands, held stable from start until done
exu_done  in  1  EXU completion pulse
exu_result  in  32  valid when exu_done=1
retired  out  1  single-cycle pulse per retired instruction

Behaviour:
- Instruction format:
  - op = [24:21]
  - rd = [20:16]
  - rs1 = [15:11]
  - rs2 = [10:6]
  - imm = [15:0]
  - [31:25] ignored.
- Opcodes:
  - 0 = NOP
  - 1..7 = EXU ops, passed through on exu_op
  - 8 = LOAD (rd <= zero-extended imm)
  - 9..15 = illegal
- Reset values:
  - All outputs 0; FIFO empty; FSM IDLE.
  - Reset mid-operation discards the FIFO and the in-flight instruction, with no pulse afterwards. The EXU shares rst.
- Host writes:
  - write && addr==CMD_ADDR && !cmd_full: push.
  - If full: drop the word and set err_overflow, even if a pop occurs in the same cycle.
  - write && addr==CLR_ADDR && data[0]: clear both error flags. A set event in the same cycle wins over the clear.
  - All other addresses are ignored.
- Push and pop in the same cycle (not full): count unchanged, order preserved. Pointers wrap modulo DEPTH.
- FSM (one instruction in flight):
  - IDLE: if FIFO non-empty, pop into the instruction register, go to DISPATCH.
  - DISPATCH:
    - NOP: retired=1, go to IDLE.
    - Illegal: err_illegal=1, retired=1, go to IDLE.
    - LOAD: go to WB, wdata = {16'h0, imm}.
    - op 1..7: drive rf_raddr1/2 = rs1/rs2, go to READ.
  - READ: latch rf_rdata1/2 into exu_a/b, go to START.
  - START: exu_start=1 for exactly this cycle, go to WAIT.
  - WAIT: exu_done is ignored in START and sampled from the following cycle. On done, latch exu_result, go to WB.
  - WB: rf_we=1, rf_waddr=rd, retired=1. If FIFO non-empty, pop and go to DISPATCH; else go to IDLE.
- Latency (write in cycle c, FIFO empty, FSM IDLE):
  - LOAD: rf_we in cycle c+3.
  - EXU op: exu_start in c+4; rf_we one cycle after the exu_done cycle.
- Write-back values:
  - rf_wdata and rf_waddr are valid only while rf_we=1.
  - No write for NOP or illegal ops.
  - An EXU result with rd=0 is written normally; the register file owns any r0 semantics.
- Outputs are registered. rf_raddr1/2 hold their last value outside READ.

Test Plan:
- Reset then idle -> all outputs 0, busy=0, cmd_count=0; assert rst mid-WAIT -> FSM IDLE, FIFO empty, no rf_we afterward.
- Write {7'h0,4'h8,5'd13,16'habcd} to CMD_ADDR in cycle c -> rf_we=1, rf_waddr=13, rf_wdata=32'h0000abcd in c+3; retired pulses in that cycle.
- Op 3, rd=3, rs1=4, rs2=5, with rf r4=32'h11, r5=32'h22:
  - exu_start in c+4 with exu_op=3, exu_a=32'h11, exu_b=32'h22.
  - exu_done with exu_result=32'h33 five cycles later -> next cycle rf_we, waddr=3, wdata=32'h33.
- Burst DEPTH+1 LOAD writes on consecutive cycles while EXU stalls an earlier op:
  - cmd_full=1 and the extra word is dropped; err_overflow=1.
  - The DEPTH queued LOADs retire in order.
  - A CLR_ADDR write with data[0]=1 clears err_overflow.
- Op 12 -> err_illegal=1, retired pulses, no rf_we, no exu_start; subsequent queued LOAD retires normally.
- Back-to-back LOADs with FIFO pre-filled -> WB->DISPATCH path gives one retirement every 2 cycles; cmd_count decrements on each pop.
